simd_issue_queue: RTL

//  Upstream issue stage for simd_core. Buffers packed 4-lane SIMD instructions in a FIFO and drives

---
 rtl/simd_issue_queue.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/simd_issue_queue.sv
// -----------------------------------------------------------------------------
// simd_issue_queue
//
// Issue stage that sits in front of the combinational simd_core. Packed 4-lane
// SIMD instructions are buffered in a small FIFO. They are popped one at a time
// into registered opcode/operand outputs that feed the core. One cycle later the
// core's r0..r3 results are captured. They are then returned on a valid/ready
// result port. Operations issue strictly in order, at most one every two cycles.
//
// Optional feature: define SIMD_ISSUE_STATS_EN to add the saturating counters
// stat_issued and stat_illegal. The functional behaviour is unchanged.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     instruction handshake; in_ready = FIFO not full
//   in_opcode             00 ADD, 01 SUB, 10 MUL, 11 illegal
//   in_a, in_b            packed operands {x3,x2,x1,x0}, 8-bit lanes
//   opcode, a0..a3, b0..b3  registered drive into simd_core
//   r0..r3                combinational lane results from simd_core
//   res_valid/res_ready   result handshake
//   res_data              {r3,r2,r1,r0}; zero for an illegal opcode
//   res_err               result came from an illegal opcode
//   stat_issued           (SIMD_ISSUE_STATS_EN) pops, saturating at 16'hFFFF
//   stat_illegal          (SIMD_ISSUE_STATS_EN) popped opcode-11 ops, saturating
// -----------------------------------------------------------------------------
module simd_issue_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_opcode,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [1:0]  opcode,
   output logic [7:0]  a0,
   output logic [7:0]  a1,
   output logic [7:0]  a2,
   output logic [7:0]  a3,
   output logic [7:0]  b0,
   output logic [7:0]  b1,
   output logic [7:0]  b2,
   output logic [7:0]  b3,
   input  logic [15:0] r0,
   input  logic [15:0] r1,
   input  logic [15:0] r2,
   input  logic [15:0] r3,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic        res_err
`ifdef SIMD_ISSUE_STATS_EN
   ,
   output logic [15:0] stat_issued,
   output logic [15:0] stat_illegal
`endif
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [1:0]  OP_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg;

   // FIFO storage: each entry is {opcode, a, b}.
   logic [65:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;

   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic [65:0] head;

   logic [1:0]  opcode_reg;
   logic [31:0] a_reg;
   logic [31:0] b_reg;

   assign full     = (count_reg == FULL_COUNT);
   assign empty    = (count_reg == '0);
   // Readiness depends only on the current occupancy. A pop in the same cycle
   // does not free a slot for a push while the FIFO is full.
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   // Pop from IDLE, or from DONE when the held result is being consumed. The
   // second case gives back-to-back issue. res_valid is always high in DONE.
   assign pop      = !empty &&
                     ((state_reg == IDLE) || ((state_reg == DONE) && res_ready));
   assign head     = mem[rd_ptr_reg];

   // Storage has no reset. Only the pointers and the count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {in_opcode, in_a, in_b};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   // Sequencer. The operand registers change only on a pop. This means the
   // core sees stable inputs for the whole EXEC cycle and keeps the last
   // operands while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         opcode_reg <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         res_data   <= '0;
         res_valid  <= 1'b0;
         res_err    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  opcode_reg <= head[65:64];
                  a_reg      <= head[63:32];
                  b_reg      <= head[31:0];
                  state_reg  <= EXEC;
               end
            end
            EXEC: begin
               res_valid <= 1'b1;
               if (opcode_reg == OP_ILLEGAL) begin
                  res_data <= '0;
                  res_err  <= 1'b1;
               end else begin
                  res_data <= {r3, r2, r1, r0};
                  res_err  <= 1'b0;
               end
               state_reg <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  // The result has been consumed, so drop valid. During a
                  // back-to-back EXEC it must not be presented a second time.
                  res_valid <= 1'b0;
                  res_err   <= 1'b0;
                  if (pop) begin
                     opcode_reg <= head[65:64];
                     a_reg      <= head[63:32];
                     b_reg      <= head[31:0];
                     state_reg  <= EXEC;
                  end else begin
                     state_reg  <= IDLE;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign opcode = opcode_reg;
   assign a0     = a_reg[7:0];
   assign a1     = a_reg[15:8];
   assign a2     = a_reg[23:16];
   assign a3     = a_reg[31:24];
   assign b0     = b_reg[7:0];
   assign b1     = b_reg[15:8];
   assign b2     = b_reg[23:16];
   assign b3     = b_reg[31:24];

`ifdef SIMD_ISSUE_STATS_EN
   logic [15:0] stat_issued_reg;
   logic [15:0] stat_illegal_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued_reg  <= '0;
         stat_illegal_reg <= '0;
      end else begin
         if (pop && (stat_issued_reg != 16'hFFFF)) begin
            stat_issued_reg <= stat_issued_reg + 16'd1;
         end
         if (pop && (head[65:64] == OP_ILLEGAL) && (stat_illegal_reg != 16'hFFFF)) begin
            stat_illegal_reg <= stat_illegal_reg + 16'd1;
         end
      end
   end

   assign stat_issued  = stat_issued_reg;
   assign stat_illegal = stat_illegal_reg;
`endif

endmodule
